// File: rtl/controller_port_poller.sv
// Polls NUM_PORTS serial NES-style pads on a fixed latch/clock schedule and
// emulates the CPU-visible strobe/read shift registers on the latest complete snapshot.
module controller_port_poller #(
    parameter int NUM_PORTS   = 2,
    parameter int BITS        = 8,
    parameter int CLK_DIV     = 30,
    parameter int POLL_PERIOD = 1000,
    parameter int AUTO_POLL   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_clk_en,
    input  logic                      i_strobe,
    input  logic [NUM_PORTS-1:0]      i_read,
    output logic [NUM_PORTS-1:0]      o_data,
    input  logic                      i_poll_req,
    output logic                      o_controller_latch,
    output logic                      o_controller_clk,
    input  logic [NUM_PORTS-1:0]      i_controller,
    output logic [NUM_PORTS*BITS-1:0] o_buttons,
    output logic                      o_snapshot_valid,
    output logic                      o_busy
);

    localparam int MAX_A = (CLK_DIV > POLL_PERIOD) ? CLK_DIV : POLL_PERIOD;
    localparam int MAX_V = (MAX_A > BITS) ? MAX_A : BITS;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BITS - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(POLL_PERIOD);

    typedef enum logic [2:0] {
        IDLE, LATCH, SAMPLE, CLK_LOW, CLK_HIGH, DONE, WAIT
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   bit_idx;
    logic [BITS-1:0] shreg  [NUM_PORTS];
    logic [BITS-1:0] cpu_sr [NUM_PORTS];
    logic            strobe_q;

    // Read-shift of the CPU register: empty positions fill with 1 like the real pad.
    function automatic logic [BITS-1:0] shift_in_one(input logic [BITS-1:0] v);
        logic [BITS-1:0] r;
        r           = v >> 1;
        r[BITS-1]   = 1'b1;
        return r;
    endfunction

    assign o_busy = (state != IDLE) && (state != WAIT);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state              <= IDLE;
            cnt                <= '0;
            bit_idx            <= '0;
            o_controller_latch <= 1'b0;
            o_controller_clk   <= 1'b1;
            o_buttons          <= '0;
            o_snapshot_valid   <= 1'b0;
        end else begin
            o_snapshot_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (AUTO_POLL != 0 || i_poll_req) begin
                        state              <= LATCH;
                        o_controller_latch <= 1'b1;
                        cnt                <= '0;
                    end
                end
                LATCH: begin
                    if (cnt == DIV_LAST) begin
                        state              <= SAMPLE;
                        o_controller_latch <= 1'b0;
                        cnt                <= '0;
                        bit_idx            <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (bit_idx == BIT_LAST) begin
                        state <= DONE;
                    end else begin
                        state            <= CLK_LOW;
                        o_controller_clk <= 1'b0;
                        cnt              <= '0;
                    end
                end
                CLK_LOW: begin
                    if (cnt == DIV_LAST) begin
                        state            <= CLK_HIGH;
                        o_controller_clk <= 1'b1;
                        cnt              <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CLK_HIGH: begin
                    if (cnt == DIV_LAST) begin
                        state   <= SAMPLE;
                        bit_idx <= bit_idx + 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    for (int p = 0; p < NUM_PORTS; p++)
                        o_buttons[p*BITS +: BITS] <= shreg[p];
                    o_snapshot_valid <= 1'b1;
                    state            <= WAIT;
                    cnt              <= '0;
                end
                WAIT: begin
                    if (i_poll_req) begin
                        state              <= LATCH;
                        o_controller_latch <= 1'b1;
                        cnt                <= '0;
                    end else if (cnt == WAIT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Snapshot capture is pure data; a reset just leaves a stale partial word behind.
    always_ff @(posedge i_clk) begin
        if (state == SAMPLE) begin
            for (int p = 0; p < NUM_PORTS; p++)
                for (int b = 0; b < BITS; b++)
                    if (bit_idx == CW'(b))
                        shreg[p][b] <= ~i_controller[p];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            strobe_q <= 1'b0;
            o_data   <= '0;
            for (int p = 0; p < NUM_PORTS; p++)
                cpu_sr[p] <= '0;
        end else if (i_clk_en) begin
            strobe_q <= i_strobe;
            for (int p = 0; p < NUM_PORTS; p++) begin
                // Strobe high or its falling edge reloads; the load beats any read shift.
                if (i_strobe || strobe_q)
                    cpu_sr[p] <= o_buttons[p*BITS +: BITS];
                else if (i_read[p])
                    cpu_sr[p] <= shift_in_one(cpu_sr[p]);
                if (i_read[p])
                    o_data[p] <= (strobe_q && !i_strobe) ? o_buttons[p*BITS] : cpu_sr[p][0];
            end
        end
    end

endmodule
